// File: rtl/data_mem_if.sv
// Load/store request and response bundle between the MEM stage (master)
// and the data-memory responder (slave).
interface data_mem_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder with programmable wait states and a single-cycle response.
// Optional MEM_PIPE_ACCEPT_EN: accept the next request during the RESP cycle.
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  data_mem_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [7:0]          data_q, data_d;
  logic                resp_valid_q, resp_valid_d;
  logic [7:0]          resp_rdata_q, resp_rdata_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  logic [7:0]          mem_q [DEPTH];

  logic                accept_s;
  logic                start_s;
  logic                go_resp_s;
  logic                mem_we_s;

  // Next-state, request latch and memory access decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    data_d       = data_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    start_s      = 1'b0;
    go_resp_s    = 1'b0;
    mem_we_s     = 1'b0;
    accept_s     = bus.req_valid && req_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          go_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        // The strobe trails the RESP state by one edge so the data captured
        // on RESP entry is stable for the whole strobe cycle.
        resp_valid_d = 1'b1;
        resp_rdata_d = data_q;
`ifdef MEM_PIPE_ACCEPT_EN
        if (accept_s) begin
          start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_s) begin
      wr_d    = bus.req_write;
      addr_d  = bus.req_addr[ADDR_W-1:0];
      wdata_d = bus.req_wdata;
      if (WAIT_CYCLES == 0) begin
        go_resp_s = 1'b1;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = CNT_INIT;
      end
    end else begin
      cnt_d = cnt_d;
    end

    // wr_d/addr_d/wdata_d already hold the fields of the request being served
    if (go_resp_s) begin
      state_d = ST_RESP;
      if (wr_d) begin
        mem_we_s = 1'b1;
        data_d   = wdata_d;
      end else begin
        data_d   = mem_q[addr_d];
      end
    end else begin
      mem_we_s = 1'b0;
    end

`ifdef MEM_PIPE_ACCEPT_EN
    req_ready_d = (state_d == ST_IDLE) || (state_d == ST_RESP);
`else
    req_ready_d = (state_d == ST_IDLE);
`endif
    busy_d = (state_d != ST_IDLE);
  end

  // State, latched request, registered outputs and memory array
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 8'h00;
      data_q       <= 8'h00;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 8'h00;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      data_q       <= data_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      if (mem_we_s) begin
        mem_q[addr_d] <= wdata_d;
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: four instances cover the default,
// ADDR_W=4, WAIT_CYCLES=0 and WAIT_CYCLES=1 configurations on one shared bus driver.
module tb_data_mem_responder;

`ifdef MEM_PIPE_ACCEPT_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  int         sel = 0;
  logic       valid = 1'b0;
  logic       write = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_mem_if if_a ();
  data_mem_if if_b ();
  data_mem_if if_c ();
  data_mem_if if_d ();

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
  data_mem_responder #(.ADDR_W(4), .WAIT_CYCLES(2)) dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));
  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_c (.clk(clk), .reset_n(reset_n), .bus(if_c));
  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) dut_d (.clk(clk), .reset_n(reset_n), .bus(if_d));

  assign if_a.req_valid = valid && (sel == 0);
  assign if_b.req_valid = valid && (sel == 1);
  assign if_c.req_valid = valid && (sel == 2);
  assign if_d.req_valid = valid && (sel == 3);
  assign if_a.req_write = write;  assign if_a.req_addr = addr;  assign if_a.req_wdata = wdata;
  assign if_b.req_write = write;  assign if_b.req_addr = addr;  assign if_b.req_wdata = wdata;
  assign if_c.req_write = write;  assign if_c.req_addr = addr;  assign if_c.req_wdata = wdata;
  assign if_d.req_write = write;  assign if_d.req_addr = addr;  assign if_d.req_wdata = wdata;

  logic [3:0] rdy_w, rv_w, bsy_w;
  logic [7:0] rd_w [4];
  assign rdy_w = {if_d.req_ready,  if_c.req_ready,  if_b.req_ready,  if_a.req_ready};
  assign rv_w  = {if_d.resp_valid, if_c.resp_valid, if_b.resp_valid, if_a.resp_valid};
  assign bsy_w = {if_d.busy,       if_c.busy,       if_b.busy,       if_a.busy};
  assign rd_w[0] = if_a.resp_rdata;
  assign rd_w[1] = if_b.resp_rdata;
  assign rd_w[2] = if_c.resp_rdata;
  assign rd_w[3] = if_d.resp_rdata;

  logic       o_ready, o_rvalid, o_busy;
  logic [7:0] o_rdata;
  assign o_ready  = rdy_w[sel[1:0]];
  assign o_rvalid = rv_w[sel[1:0]];
  assign o_busy   = bsy_w[sel[1:0]];
  assign o_rdata  = rd_w[sel[1:0]];

  function automatic int wait_of(input int s);
    case (s)
      0:       return 2;
      1:       return 2;
      2:       return 0;
      3:       return 1;
      default: return 2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request on the selected instance; checks latency, data and a single strobe.
  task automatic do_req(input string tag, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp_data);
    int lat;
    bit got;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 20 && !o_ready; i++) @(negedge clk);
    write = w; addr = a; wdata = d; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    for (int m = 0; m < 20; m++) begin
      @(negedge clk);
      if (m == 0) check({tag, "_busy"}, 32'(o_busy), 32'd1);
      if (o_rvalid) begin
        lat = m;
        got = 1'b1;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(wait_of(sel) + 1));
    check({tag, "_data"}, 32'(o_rdata), 32'(exp_data));
    @(negedge clk);
    check({tag, "_strobe_once"}, 32'(o_rvalid), 32'd0);
  endtask

  int   nresp;
  int   issued;
  int   busy_drops;
  logic prev_ready;
  int   resp_cyc [4];
  logic [7:0] resp_dat [4];
  logic ready_hist [64];
  int   strobes;

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_rvalid", 32'(o_rvalid), 32'd0);
    check("rst_rdata", 32'(o_rdata), 32'h00);
    check("rst_busy", 32'(o_busy), 32'd0);
    reset_n = 1'b1;

    // Store then load, default configuration
    sel = 0;
    do_req("st_a5", 1'b1, 8'h10, 8'hA5, 8'hA5);
    do_req("ld_a5", 1'b0, 8'h10, 8'h00, 8'hA5);
    do_req("st_5a", 1'b1, 8'hFF, 8'h5A, 8'h5A);
    do_req("ld_5a", 1'b0, 8'hFF, 8'h00, 8'h5A);
    do_req("ld_unw", 1'b0, 8'h11, 8'h00, 8'h00);

    // Request held valid with changing fields during WAIT
    @(negedge clk);
    write = 1'b1; addr = 8'h40; wdata = 8'h77; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hold_ready0", 32'(o_ready), 32'd0);
    addr = 8'h41; wdata = 8'h88;
    @(negedge clk);
    check("hold_ready1", 32'(o_ready), 32'd0);
    addr = 8'h42; wdata = 8'h99;
    valid = 1'b0;
    strobes = 0;
    for (int k = 0; k < 6; k++) begin
      if (o_rvalid) begin
        strobes++;
        check("hold_data", 32'(o_rdata), 32'h77);
      end
      @(negedge clk);
    end
    check("hold_strobes", 32'(strobes), 32'd1);
    do_req("hold_ld41", 1'b0, 8'h41, 8'h00, 8'h00);
    do_req("hold_ld40", 1'b0, 8'h40, 8'h00, 8'h77);

    // ADDR_W=4 address aliasing
    sel = 1;
    do_req("alias_st", 1'b1, 8'h13, 8'h3C, 8'h3C);
    do_req("alias_ld", 1'b0, 8'h03, 8'h00, 8'h3C);

    // WAIT_CYCLES=0
    sel = 2;
    do_req("w0_st", 1'b1, 8'h05, 8'h99, 8'h99);
    do_req("w0_ld", 1'b0, 8'h05, 8'h00, 8'h99);

    // Reset during WAIT of a pending store
    sel = 0;
    @(negedge clk);
    write = 1'b1; addr = 8'h20; wdata = 8'hFF; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    check("mid_busy", 32'(o_busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(o_ready), 32'd1);
    check("mid_rst_rvalid", 32'(o_rvalid), 32'd0);
    check("mid_rst_rdata", 32'(o_rdata), 32'h00);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    check("post_rst_ready", 32'(o_ready), 32'd1);
    do_req("post_rst_ld", 1'b0, 8'h20, 8'h00, 8'h00);

    // Back-to-back loads with WAIT_CYCLES=1
    sel = 3;
    do_req("d_st0", 1'b1, 8'h00, 8'h11, 8'h11);
    do_req("d_st1", 1'b1, 8'h01, 8'h22, 8'h22);
    do_req("d_st2", 1'b1, 8'h02, 8'h33, 8'h33);
    do_req("d_st3", 1'b1, 8'h03, 8'h44, 8'h44);
    @(negedge clk);
    write = 1'b0; addr = 8'h00; valid = 1'b1;
    issued = 0; nresp = 0; busy_drops = 0;
    prev_ready = o_ready;
    ready_hist[0] = o_ready;
    for (int k = 1; k < 40 && nresp < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid && prev_ready) begin
        issued++;
        if (issued == 4) valid = 1'b0;
        else addr = 8'(issued);
      end
      if (issued > 0 && !o_busy && !(o_rvalid && nresp == 3)) busy_drops++;
      if (o_rvalid) begin
        resp_cyc[nresp] = k;
        resp_dat[nresp] = o_rdata;
        check("bb_ready_in_resp", 32'(ready_hist[k-1]), 32'(PIPE));
        nresp++;
      end
      ready_hist[k] = o_ready;
      prev_ready = o_ready;
    end
    valid = 1'b0;
    check("bb_nresp", 32'(nresp), 32'd4);
    if (nresp == 4) begin
      check("bb_first_lat", 32'(resp_cyc[0]), 32'd3);
      for (int i = 0; i < 3; i++)
        check("bb_period", 32'(resp_cyc[i+1] - resp_cyc[i]), 32'(PIPE ? 2 : 3));
      for (int i = 0; i < 4; i++)
        check("bb_data", 32'(resp_dat[i]), 32'(8'h11 * (i + 1)));
    end
    check("bb_busy_drops", 32'(busy_drops), 32'(PIPE ? 0 : 3));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the pipeline's data-memory interface: accepts one load/store request at a time from the MEM stage over a valid/ready handshake.
- Inserts a programmable number of wait states, then returns a single-cycle response carrying read data (or a store acknowledge).
- Sits behind the MEM stage in place of a zero-latency data memory; the `busy` output is the pipeline stall source.

Parameters:
- ADDR_W, 8, byte-address bits actually decoded; depth = 2^ADDR_W bytes (legal 4..8).
- WAIT_CYCLES, 2, wait states between accept and response (legal 0..15).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  8  byte address; upper 8-ADDR_W bits ignored
- req_wdata  in  8  store data
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  8  load data, or echo of store data
- busy  out  1  request in flight (state != IDLE)

Behaviour:
- Reset (reset_n low, async):
  - State goes to IDLE, wait counter to 0.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=8'h00, busy=0.
  - All memory bytes cleared to 8'h00.
  - Latched request fields cleared.
- Acceptance:
  - Occurs on an edge where req_valid && req_ready.
  - That edge latches write, addr[ADDR_W-1:0] and wdata.
  - Request inputs are ignored on every other edge and may change freely.
- States:
  - IDLE: req_ready=1. On accept, go to WAIT and load counter with WAIT_CYCLES-1; if WAIT_CYCLES=0, go directly to RESP.
  - WAIT: req_ready=0. Counter decrements each cycle; when it is 0, go to RESP on the next edge.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE. There is no response backpressure.
- Memory access takes effect on the edge entering RESP:
  - Store: writes mem[addr] and loads resp_rdata with wdata.
  - Load: loads resp_rdata with mem[addr].
- resp_rdata holds its value until the next response or reset.
- Latency: resp_valid is high in the cycle beginning WAIT_CYCLES+1 edges after the accept edge.
  - Example: WAIT_CYCLES=2 → accept at edge 0, resp_valid high in cycle after edge 3.
- Throughput (base build): one request per WAIT_CYCLES+2 cycles.
- Address wrap: with ADDR_W<8, the address is truncated, so addr 8'h13 and 8'h03 alias when ADDR_W=4.
- Load after store to the same address returns the new data, because the store is committed before the next accept.
- Reset mid-operation:
  - Reset asserted before the RESP-entry edge: a pending store is dropped and no response is produced.
  - After reset deassertion, the first accept is possible on the first edge.
- busy = (state != IDLE); it is registered-state derived and glitch-free relative to clk.

Optional Feature:
- Macro: MEM_PIPE_ACCEPT_EN.
- Defined:
  - req_ready is also 1 in RESP.
  - A request accepted on the RESP→exit edge goes straight to WAIT (or RESP if WAIT_CYCLES=0), skipping IDLE.
  - Throughput becomes one per WAIT_CYCLES+1 cycles.
  - busy stays high across back-to-back requests.
- Undefined: req_ready is 1 only in IDLE, as in the base behaviour.

Test Plan:
- Reset, then store 8'hA5 to addr 8'h10, then load 8'h10 (WAIT_CYCLES=2):
  - Each resp_valid arrives exactly 3 edges after its accept.
  - Load returns 8'hA5; store echo is 8'hA5.
- req_valid held high with varying addr/wdata during WAIT:
  - req_ready=0 throughout.
  - Only the accepted request's fields are used; resp_valid pulses exactly once.
- ADDR_W=4: store 8'h3C to 8'h13, load 8'h03 → resp_rdata=8'h3C.
- WAIT_CYCLES=0: accept at edge 0 → resp_valid in the cycle after edge 1; resp_rdata correct.
- Assert reset_n low for 1 cycle while a store of 8'hFF to 8'h20 is in WAIT:
  - No resp_valid.
  - Subsequent load of 8'h20 returns 8'h00.
  - Outputs are at reset values immediately (async).
- MEM_PIPE_ACCEPT_EN, WAIT_CYCLES=1, req_valid continuously high with 4 loads:
  - Responses every 2 cycles.
  - req_ready high in each RESP cycle.
  - busy never drops until after the last response.
